// File: rtl/vm_pkg.sv
// Shared types and helpers for the multi-item vending controller.
// State encoding, coin weights and the price-table slice function.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAY    = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam int COIN_10_UNITS = 1;
  localparam int COIN_50_UNITS = 5;

  localparam int TABLE_MAX_W = 256;
  localparam int PRICE_MAX_W = 16;

  // Entry idx of a packed table whose entries are w bits wide (w <= PRICE_MAX_W).
  function automatic logic [PRICE_MAX_W-1:0] price_slice(
    input logic [TABLE_MAX_W-1:0] tbl,
    input int                     idx,
    input int                     w
  );
    logic [TABLE_MAX_W-1:0] shifted;
    logic [PRICE_MAX_W-1:0] mask;
    shifted = tbl >> (idx * w);
    mask    = (PRICE_MAX_W'(1) << w) - PRICE_MAX_W'(1);
    return shifted[PRICE_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-item stock counters: reload-all, decrement-one, sold-out flags.
// Counters update one edge after load/dec; sold_out is combinational from the counters.
module vm_stock_bank
  import vm_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       dec,
  input  logic [$clog2(N_ITEMS)-1:0] dec_idx,
  output logic [N_ITEMS-1:0]         sold_out
);

  logic [STOCK_W-1:0] stock [N_ITEMS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else if (load) begin
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else if (dec && stock[dec_idx] != '0) begin
      stock[dec_idx] <= stock[dec_idx] - STOCK_W'(1);
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < N_ITEMS; i++) sold_out[i] = (stock[i] == '0);
  end

endmodule

// File: rtl/vending_machine_multi.sv
// N-item vending controller: coin credit, price table, stock, cancel/refund, serial change.
// Coin edge reaching the price releases the item next cycle; change is one unit per cycle.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int                           N_ITEMS     = 4,
  parameter int                           PRICE_W     = 4,
  parameter logic [N_ITEMS*PRICE_W-1:0]   PRICE_TABLE = 16'h4321,
  parameter int                           CREDIT_W    = 8,
  parameter int                           STOCK_W     = 4,
  parameter int                           INIT_STOCK  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(N_ITEMS)-1:0] item,
  input  logic                       sel,
  input  logic                       dollar_10,
  input  logic                       dollar_50,
  input  logic                       cancel,
  input  logic                       restock,
  output logic [PRICE_W-1:0]         price,
  output logic [CREDIT_W-1:0]        credit,
  output logic [N_ITEMS-1:0]         item_rels,
  output logic                       change_return,
  output logic                       coin_reject,
  output logic                       sel_reject,
  output logic [N_ITEMS-1:0]         sold_out
);

  localparam int IDX_W = $clog2(N_ITEMS);
  localparam int LUT_N = 1 << IDX_W;
  localparam logic [TABLE_MAX_W-1:0] TABLE_EXT = TABLE_MAX_W'(PRICE_TABLE);

  state_t               state;
  logic [IDX_W-1:0]     latched;
  logic [PRICE_W-1:0]   price_lut [LUT_N];
  logic [LUT_N-1:0]     blocked;
  logic [2:0]           units;
  logic [CREDIT_W:0]    sum;
  logic                 coin_in;
  logic                 coin_fits;
  logic [CREDIT_W-1:0]  credit_upd;
  logic [CREDIT_W-1:0]  vend_credit;
  logic                 sel_ok;
  logic                 sel_bad;
  logic [IDX_W-1:0]     pay_item;
  logic [PRICE_W-1:0]   pay_price;
  logic                 restock_load;
  logic                 vend_dec;

  for (genvar i = 0; i < LUT_N; i++) begin : g_price
    assign price_lut[i] = PRICE_W'(price_slice(TABLE_EXT, i, PRICE_W));
  end

  always_comb begin
    units      = (dollar_10 ? 3'(COIN_10_UNITS) : 3'd0)
               + (dollar_50 ? 3'(COIN_50_UNITS) : 3'd0);
    coin_in    = dollar_10 | dollar_50;
    sum        = {1'b0, credit} + (CREDIT_W + 1)'(units);
    coin_fits  = !sum[CREDIT_W];
    credit_upd = coin_fits ? sum[CREDIT_W-1:0] : credit;

    // Indices past N_ITEMS behave as permanently sold out.
    blocked              = '1;
    blocked[N_ITEMS-1:0] = sold_out;
    sel_ok     = sel && !blocked[item];
    sel_bad    = sel && blocked[item];

    pay_item    = sel_ok ? item : latched;
    pay_price   = price_lut[pay_item];
    vend_credit = credit - CREDIT_W'(price_lut[latched]);
  end

  assign restock_load = (state == IDLE) && restock;
  assign vend_dec     = (state == VEND);

  vm_stock_bank #(
    .N_ITEMS    (N_ITEMS),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk      (clk),
    .reset    (reset),
    .load     (restock_load),
    .dec      (vend_dec),
    .dec_idx  (latched),
    .sold_out (sold_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      credit        <= '0;
      latched       <= '0;
      price         <= '0;
      item_rels     <= '0;
      change_return <= 1'b0;
      coin_reject   <= 1'b0;
      sel_reject    <= 1'b0;
    end else begin
      item_rels     <= '0;
      change_return <= 1'b0;
      coin_reject   <= 1'b0;
      sel_reject    <= 1'b0;
      case (state)
        IDLE: begin
          credit      <= credit_upd;
          coin_reject <= coin_in && !coin_fits;
          if (!restock && sel) begin
            if (sel_ok) begin
              latched <= item;
              price   <= price_lut[item];
              state   <= PAY;
            end else begin
              sel_reject <= 1'b1;
            end
          end
        end
        PAY: begin
          if (cancel) begin
            coin_reject <= coin_in;
            price       <= '0;
            if (credit != '0) begin
              state         <= CHANGE;
              change_return <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            credit      <= credit_upd;
            coin_reject <= coin_in && !coin_fits;
            sel_reject  <= sel_bad;
            latched     <= pay_item;
            price       <= pay_price;
            if (credit_upd >= CREDIT_W'(pay_price)) begin
              state     <= VEND;
              item_rels <= N_ITEMS'(1) << pay_item;
            end
          end
        end
        VEND: begin
          coin_reject <= coin_in;
          credit      <= vend_credit;
          price       <= '0;
          if (vend_credit != '0) begin
            state         <= CHANGE;
            change_return <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        CHANGE: begin
          coin_reject <= coin_in;
          if (credit <= CREDIT_W'(1)) begin
            credit <= '0;
            state  <= IDLE;
          end else begin
            credit        <= credit - CREDIT_W'(1);
            change_return <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vending_machine_multi.md
# vending_machine_multi

Parametrised successor to the two-coin vending controller. It supports N items with a per-item price table, per-item stock counters with sold-out flags, and a cancel/refund path. Change is dispensed serially, one $10 unit per cycle. The block sits between the coin/keypad front end and the dispenser/coin-hopper drivers.

## Interface
- N_ITEMS, 4, number of selectable items (≥2)
- PRICE_W, 4, width of one price entry, in $10 units
- PRICE_TABLE, 16'h4321, packed prices; item i price = PRICE_TABLE[i*PRICE_W +: PRICE_W]; every entry must be nonzero
- CREDIT_W, 8, credit register width, in $10 units
- STOCK_W, 4, per-item stock counter width
- INIT_STOCK, 5, stock loaded at reset and on restock
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- item  in  $clog2(N_ITEMS)  item index, sampled with sel
- sel  in  1  select strobe (level, sampled each edge)
- dollar_10  in  1  $10 coin, +1 unit per sampled-high edge
- dollar_50  in  1  $50 coin, +5 units per sampled-high edge
- cancel  in  1  abort purchase and refund credit
- restock  in  1  reload all stock counters to INIT_STOCK (honoured in IDLE only)
- price  out  PRICE_W  price of the latched item; 0 when none is latched
- credit  out  CREDIT_W  current credit
- item_rels  out  N_ITEMS  one-hot release pulse
- change_return  out  1  one pulse per $10 unit returned
- coin_reject  out  1  pulse when a coin was not accepted
- sel_reject  out  1  pulse when the selected item is sold out
- sold_out  out  N_ITEMS  bit i = (stock[i]==0)

## Operation
- States: IDLE, PAY, VEND, CHANGE. All outputs and the credit register are registered.
- Reset values: state IDLE, credit 0, latched item 0, price 0, item_rels 0, change_return 0, coin_reject 0, sel_reject 0, all stock = INIT_STOCK, sold_out 0.
- Coins in IDLE/PAY: credit += dollar_10 + 5·dollar_50. When both coins are high on the same edge, credit += 6.
  - If the sum exceeds 2^CREDIT_W−1, neither coin is added and coin_reject pulses.
- Coins in VEND/CHANGE are never added; coin_reject pulses.
- IDLE:
  - sel with stock[item] > 0: latch item, go to PAY.
  - sel with stock[item] == 0: sel_reject pulses; stay in IDLE.
  - restock: reload all stock counters; it has priority over sel on the same edge.
- PAY:
  - sel with a different in-stock item re-latches the item; credit is kept.
  - sel with a sold-out item: sel_reject pulses; the previous latch is kept.
  - On any edge where the updated credit ≥ price, go to VEND. This includes credit carried in from IDLE.
  - cancel: go to CHANGE if credit > 0, else to IDLE. cancel has priority over coins and sel on the same edge.
- VEND (exactly one cycle):
  - item_rels[latched] = 1.
  - stock[latched] −= 1; credit −= price.
  - Next state is CHANGE if the remaining credit > 0, else IDLE.
- CHANGE:
  - change_return = 1 each cycle; credit −= 1 per cycle.
  - Leave for IDLE after the cycle in which credit reaches 0.
  - cancel and sel are ignored.
- price is 0 in IDLE and CHANGE.

## Timing
- Credit updates one edge after a coin is sampled and becomes visible on credit in the following cycle.
- Coin edge that makes credit ≥ price → item_rels is high during the next cycle (1-cycle latency).
- Refund of K units: change_return is high for exactly K consecutive cycles, starting the cycle after VEND or after the cancel edge.
- sold_out is combinational from the stock registers, so it reflects a decrement in the cycle after VEND.
- Reset mid-operation, in any state: immediate return to reset values. Credit is discarded and no change is paid.

## Structure
- Package vm_pkg:
  - state enum (IDLE/PAY/VEND/CHANGE)
  - COIN_10_UNITS = 1, COIN_50_UNITS = 5
  - price-slice helper function
- Sub-module vm_stock_bank:
  - N_ITEMS stock counters with load-all (restock), decrement-one (vend index) and sold_out vector
  - instantiated once

## Test plan
- Reset, sel item=2 (price 3), dollar_10 on 3 edges → item_rels=4'b0100 for 1 cycle, no change_return, stock[2]=4.
- sel item=0 (price 1), one dollar_50 → item_rels=4'b0001, then change_return high 4 consecutive cycles, credit ends at 0.
- sel item=3 (price 4), two dollar_10, cancel → change_return high 2 cycles, item_rels never set, stock[3] stays 5.
- Vend item=1 five times → sold_out[1]=1; next sel item=1 → sel_reject pulse, state stays IDLE; restock → sold_out=0.
- Credit at 253, dollar_50 → coin_reject pulse, credit stays 253; dollar_10 during CHANGE → coin_reject.
- Reset asserted during CHANGE with 3 units pending → change_return=0 immediately, credit=0, all stock=5.
